dds_phase_gen: RTL and testbench
================================

# dds_phase_gen

Phase-accumulator address generator for the sine lookup ROM. Accumulates a frequency tuning word each cycle and drives `rom_ce`/`rom_addr` of the sine ROM, which has one cycle of read latency. It produces a `dat_vld` strobe, a wrap marker and a `done` pulse aligned with the ROM `data` output, so downstream logic can consume samples without its own latency bookkeeping.

## Interface
- `AW`, 8: ROM address width; must match the ROM.
- `PW`, 32: phase accumulator width (PW ≥ AW).
- `CW`, 16: burst length counter width.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `stop`  in  1  end a burst early; sampled only in RUN.
- `ftw`  in  PW  frequency tuning word; latched on an accepted start.
- `poff`  in  AW  phase offset added to the address; latched on start.
- `burst_len`  in  CW  number of samples; 0 means continuous until stop. Latched on start.
- `busy`  out  1  high in RUN and FLUSH.
- `rom_ce`  out  1  address valid to the ROM.
- `rom_addr`  out  AW  ROM address.
- `dat_vld`  out  1  ROM `data` is valid this cycle.
- `dat_wrap`  out  1  qualifies `dat_vld`; this sample's phase wrapped.
- `done`  out  1  one-cycle pulse on the last `dat_vld` of a burst.

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN on `start` with `stop` low. `start` and `stop` high together in IDLE: stay in IDLE.
  - RUN → FLUSH on `stop`, or when the last address of a non-zero burst is issued.
  - FLUSH → IDLE unconditionally after 1 cycle.
- Phase: `phase_n = n*ftw_r mod 2^PW`, with `phase_0 = 0`.
- Address: `addr_n = phase_n[PW-1:PW-AW] + poff_r mod 2^AW`.
- Wrap: `wrap_n` is the carry out of `phase_{n-1} + ftw_r`. `wrap_0 = 0`.
- Sample counter: counts issued addresses. With `burst_len = N > 0`, exactly N addresses are issued. Count compare uses CW bits.
- Latched values: `ftw`, `poff` and `burst_len` changes during RUN or FLUSH have no effect.
- `start` while busy is ignored.
- `stop` in FLUSH or IDLE is ignored.
- The data stage is a one-cycle delay of (`rom_ce`, `wrap`):
  - `dat_vld = rom_ce` delayed by 1.
  - `dat_wrap` = delayed wrap ANDed with the delayed `rom_ce`.
- `done` = FLUSH state (registered) and coincides with the final `dat_vld`.
- `ftw = 0`: constant address `poff`, never wraps.

## Timing
- All outputs are registered. Reset values: all outputs 0, state IDLE, phase 0, counter 0.
- Reset mid-operation clears everything immediately. No `done` is produced.
- Burst timeline, with `start` sampled at edge E0 and `burst_len = N`:
  - Cycles 1..N (after edges E0..E(N-1)): `rom_ce` = 1, `rom_addr = addr_{c-1}`.
  - Cycles 2..N+1: `dat_vld` = 1 with ROM data for sample c-2.
  - Cycle N+1 (FLUSH): `rom_ce` = 0, `done` = 1.
  - `busy` = 1 in cycles 1..N+1.
  - Cycle N+2: IDLE. A new `start` can be sampled at the end of cycle N+2, at the earliest.
- Stop: `stop` sampled at the edge ending RUN cycle k (address k-1 on the bus).
  - Cycle k+1 is FLUSH: `rom_ce` = 0, `dat_vld` = 1 for sample k-1, `done` = 1.
  - Total samples delivered = k.
  - `stop` on the same edge as burst completion gives an identical result.
- `burst_len = 1`: one address in cycle 1, FLUSH in cycle 2.

## Test plan
1. `ftw=0x01000000`, `poff=0`, `burst_len=4` (defaults):
   - `rom_addr` = 00, 01, 02, 03 in cycles 1–4.
   - `dat_vld` in cycles 2–5.
   - `done` in cycle 5 only; `dat_wrap` always 0.
2. `ftw=0x40000000`, `poff=0xF0`, `burst_len=6`:
   - Addresses F0, 30, 70, B0, F0, 30.
   - `dat_wrap` high only with the 5th `dat_vld`.
3. `ftw=0x00800000`, `burst_len=4`: addresses 00, 00, 01, 01.
4. Continuous run with `burst_len=0`, `ftw=0x01000000`, `stop` pulsed after the 10th address:
   - Exactly 10 `dat_vld`, addresses 00–09.
   - `done` with the 10th `dat_vld`; `rom_ce` low in the same cycle.
5. Ignored-input checks:
   - `start` pulsed during RUN: no restart.
   - `ftw` changed mid-burst: address sequence unchanged.
   - `start` and `stop` together in IDLE: `busy` stays 0.
6. `rst` asserted in RUN cycle 3 of an 8-sample burst:
   - All outputs 0 immediately; no `done`.
   - A subsequent `start` produces a full correct burst starting at `poff`.

Source files
------------

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase-accumulator address generator for a sine lookup ROM.
// Issues one ROM address per cycle while running. The data-side strobes
// (dat_vld, dat_wrap, done) are delayed one cycle so they line up with the
// ROM's registered read data.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; all strobes low
//   RUN    | one address issued per cycle, phase advanced by ftw_q
//   FLUSH  | no address; last ROM word returns; done pulses
module dds_phase_gen #(
  parameter int AW = 8,
  parameter int PW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [PW-1:0] ftw,
  input  logic [AW-1:0] poff,
  input  logic [CW-1:0] burst_len,
  output logic          busy,
  output logic          rom_ce,
  output logic [AW-1:0] rom_addr,
  output logic          dat_vld,
  output logic          dat_wrap,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;

  // Burst configuration captured when start is accepted.
  logic [PW-1:0] ftw_q, ftw_d;
  logic [AW-1:0] poff_q, poff_d;
  logic [CW-1:0] len_q, len_d;

  // phase_q holds the phase of the NEXT address to issue; carry_q is the
  // wrap flag belonging to that same phase, so both travel together.
  logic [PW-1:0] phase_q, phase_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Address stage.
  logic          busy_q, busy_d;
  logic          rom_ce_q, rom_ce_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          wrap_q, wrap_d;

  // Data stage, aligned with ROM read data.
  logic          dat_vld_q, dat_vld_d;
  logic          dat_wrap_q, dat_wrap_d;
  logic          done_q, done_d;

  logic [PW:0]   phase_sum;
  logic [AW-1:0] next_addr;
  logic          last_issued;

  // Datapath helpers: next phase with its carry, and the address for phase_q.
  always_comb begin
    phase_sum   = {1'b0, phase_q} + {1'b0, ftw_q};
    next_addr   = phase_q[PW-1 -: AW] + poff_q;
    // A zero length means continuous, so the count compare is disabled.
    last_issued = (len_q != '0) && (cnt_q == len_q);
  end

  // Next-state and next-output logic for the controller and both stages.
  always_comb begin
    state_d    = state_q;
    ftw_d      = ftw_q;
    poff_d     = poff_q;
    len_d      = len_q;
    phase_d    = phase_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    rom_ce_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    wrap_d     = 1'b0;
    dat_vld_d  = rom_ce_q;
    dat_wrap_d = wrap_q & rom_ce_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start together with stop is treated as a cancelled request.
        if (start && !stop) begin
          state_d    = S_RUN;
          ftw_d      = ftw;
          poff_d     = poff;
          len_d      = burst_len;
          // Address 0 (phase 0) goes out right away; accumulator jumps to
          // phase 1, whose carry out of 0 + ftw is always zero.
          phase_d    = ftw;
          carry_d    = 1'b0;
          cnt_d      = CW'(1);
          busy_d     = 1'b1;
          rom_ce_d   = 1'b1;
          rom_addr_d = poff;
          wrap_d     = 1'b0;
        end
      end

      S_RUN: begin
        if (stop || last_issued) begin
          state_d = S_FLUSH;
          done_d  = 1'b1;
        end else begin
          rom_ce_d   = 1'b1;
          rom_addr_d = next_addr;
          wrap_d     = carry_q;
          phase_d    = phase_sum[PW-1:0];
          carry_d    = phase_sum[PW];
          cnt_d      = cnt_q + CW'(1);
        end
      end

      S_FLUSH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ftw_q      <= '0;
      poff_q     <= '0;
      len_q      <= '0;
      phase_q    <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rom_ce_q   <= 1'b0;
      rom_addr_q <= '0;
      wrap_q     <= 1'b0;
      dat_vld_q  <= 1'b0;
      dat_wrap_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ftw_q      <= ftw_d;
      poff_q     <= poff_d;
      len_q      <= len_d;
      phase_q    <= phase_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rom_ce_q   <= rom_ce_d;
      rom_addr_q <= rom_addr_d;
      wrap_q     <= wrap_d;
      dat_vld_q  <= dat_vld_d;
      dat_wrap_q <= dat_wrap_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rom_ce   = rom_ce_q;
  assign rom_addr = rom_addr_q;
  assign dat_vld  = dat_vld_q;
  assign dat_wrap = dat_wrap_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Testbench for dds_phase_gen: directed and random bursts checked cycle by
// cycle against an arithmetic model of the phase/address/wrap sequence.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] ftw;
  logic [7:0]  poff;
  logic [15:0] burst_len;
  logic        busy;
  logic        rom_ce;
  logic [7:0]  rom_addr;
  logic        dat_vld;
  logic        dat_wrap;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] addr_log[$];
  int         wrap_log[$];

  dds_phase_gen #(.AW(8), .PW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ftw(ftw), .poff(poff), .burst_len(burst_len),
    .busy(busy), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .dat_vld(dat_vld), .dat_wrap(dat_wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: address n = top byte of (n*ftw mod 2^32) plus offset.
  function automatic logic [7:0] m_addr(input logic [31:0] f, input logic [7:0] p, input int n);
    logic [63:0] ph;
    ph = (64'(n) * 64'(f)) % 64'h1_0000_0000;
    return ph[31:24] + p;
  endfunction

  // Reference: sample n wrapped if phase_{n-1} + ftw overflowed 32 bits.
  function automatic logic m_wrap(input logic [31:0] f, input int n);
    logic [63:0] prev;
    if (n == 0) return 1'b0;
    prev = (64'(n - 1) * 64'(f)) % 64'h1_0000_0000;
    return (prev + 64'(f)) >= 64'h1_0000_0000;
  endfunction

  // Cycle c of a burst that delivers m samples (c=1 is the cycle after start).
  task automatic check_cycle(input string tag, input int c, input int m,
                             input logic [31:0] f, input logic [7:0] p);
    logic e_busy, e_ce, e_vld, e_wrap, e_done;
    e_busy = (c >= 1) && (c <= m + 1);
    e_ce   = (c >= 1) && (c <= m);
    e_vld  = (c >= 2) && (c <= m + 1);
    e_wrap = e_vld && m_wrap(f, c - 2);
    e_done = (c == m + 1);
    check($sformatf("%s c%0d busy", tag, c), 64'(busy), 64'(e_busy));
    check($sformatf("%s c%0d rom_ce", tag, c), 64'(rom_ce), 64'(e_ce));
    if (e_ce) check($sformatf("%s c%0d rom_addr", tag, c), 64'(rom_addr), 64'(m_addr(f, p, c - 1)));
    check($sformatf("%s c%0d dat_vld", tag, c), 64'(dat_vld), 64'(e_vld));
    check($sformatf("%s c%0d dat_wrap", tag, c), 64'(dat_wrap), 64'(e_wrap));
    check($sformatf("%s c%0d done", tag, c), 64'(done), 64'(e_done));
    if (rom_ce === 1'b1) addr_log.push_back(rom_addr);
    if (dat_vld === 1'b1 && dat_wrap === 1'b1) wrap_log.push_back(c - 1);
  endtask

  // Runs one burst from IDLE. stop_k>0 raises stop in cycle k. With noise,
  // start/ftw/poff/burst_len are scrambled while busy and stop is raised in
  // FLUSH and the following IDLE cycle; none of it may disturb the burst.
  task automatic run_burst(input string tag, input logic [31:0] f, input logic [7:0] p,
                           input logic [15:0] len, input int stop_k, input bit noise);
    int m;
    if (len == 0) m = stop_k;
    else if (stop_k != 0 && stop_k < int'(len)) m = stop_k;
    else m = int'(len);
    addr_log.delete();
    wrap_log.delete();
    ftw = f; poff = p; burst_len = len; start = 1'b1; stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= m + 2; c++) begin
      check_cycle(tag, c, m, f, p);
      stop = (c == stop_k);
      if (noise) begin
        ftw       = $urandom;
        poff      = 8'($urandom);
        burst_len = 16'($urandom);
        start     = (c <= m + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (c == 3) start = 1'b1;
        if (c >= m + 1) stop = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " rom_ce"}, 64'(rom_ce), 64'd0);
    check({tag, " rom_addr"}, 64'(rom_addr), 64'd0);
    check({tag, " dat_vld"}, 64'(dat_vld), 64'd0);
    check({tag, " dat_wrap"}, 64'(dat_wrap), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [7:0]  exp_t2[6];
    logic [31:0] rf;
    logic [7:0]  rp;
    logic [15:0] rl;
    int          rk;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    ftw = '0; poff = '0; burst_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: unit step, four samples, no wrap.
    run_burst("t1", 32'h0100_0000, 8'h00, 16'd4, 0, 1'b0);
    check("t1 addr count", 64'(addr_log.size()), 64'd4);

    // 2: quarter-turn step with offset; wrap on the 5th sample.
    run_burst("t2", 32'h4000_0000, 8'hF0, 16'd6, 0, 1'b0);
    exp_t2 = '{8'hF0, 8'h30, 8'h70, 8'hB0, 8'hF0, 8'h30};
    check("t2 addr count", 64'(addr_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++)
      check($sformatf("t2 literal addr%0d", i), 64'(addr_log[i]), 64'(exp_t2[i]));
    check("t2 wrap count", 64'(wrap_log.size()), 64'd1);
    if (wrap_log.size() > 0) check("t2 wrap sample", 64'(wrap_log[0]), 64'd5);

    // 3: half-step ftw, each address repeated.
    run_burst("t3", 32'h0080_0000, 8'h00, 16'd4, 0, 1'b0);

    // 4: continuous, stopped after the 10th address.
    run_burst("t4", 32'h0100_0000, 8'h00, 16'd0, 10, 1'b0);
    check("t4 addr count", 64'(addr_log.size()), 64'd10);

    // 5: ignored inputs while busy, and start+stop together in IDLE.
    run_burst("t5", $urandom, 8'($urandom), 16'd12, 0, 1'b1);
    ftw = 32'h0100_0000; burst_len = 16'd4; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("t5 start+stop busy", 64'(busy), 64'd0);
    check("t5 start+stop rom_ce", 64'(rom_ce), 64'd0);
    @(posedge clk); #1;
    check("t5 start+stop busy2", 64'(busy), 64'd0);

    // Boundaries: stop on the completion edge, single sample, zero ftw.
    run_burst("stop_eq", 32'h3300_0001, 8'h11, 16'd5, 5, 1'b0);
    run_burst("len1", 32'h1234_5678, 8'h80, 16'd1, 0, 1'b0);
    run_burst("ftw0", 32'h0000_0000, 8'h5A, 16'd6, 0, 1'b0);

    // 6: reset in RUN cycle 3 of an 8-sample burst.
    ftw = 32'h0100_0000; poff = 8'h20; burst_len = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_cycle("t6pre", c, 8, 32'h0100_0000, 8'h20);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    #1;
    check_all_zero("t6 rst");
    repeat (2) begin
      @(posedge clk); #1;
      check("t6 rst done", 64'(done), 64'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("t6 post busy", 64'(busy), 64'd0);
      check("t6 post done", 64'(done), 64'd0);
    end
    run_burst("t6", 32'h0100_0000, 8'h20, 16'd8, 0, 1'b0);

    // Random bursts.
    for (int i = 0; i < 20; i++) begin
      rf = $urandom;
      rp = 8'($urandom);
      rl = 16'($urandom_range(0, 20));
      if (rl == 0) rk = $urandom_range(1, 25);
      else rk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, int'(rl) + 1) : 0;
      run_burst($sformatf("rnd%0d", i), rf, rp, rl, rk, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
